// File: rtl/hexdisp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hexdisp_pkg
// Description : Shared scan-state encoding and seven-segment constants.
// Revision    : 1.0 - initial release
// ============================================================================
package hexdisp_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low g..a patterns, entry 15 (F) first down to entry 0.
    localparam logic [15:0][6:0] SEG_MAP = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage : hexdisp_pkg
`default_nettype wire

// File: rtl/hex_segment_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hex_segment_decoder
// Description : Combinational hex nibble to active-low seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_segment_decoder
    import hexdisp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_MAP[nibble_i];

endmodule : hex_segment_decoder
`default_nettype wire

// File: rtl/hex_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_controller
// Description : Time-multiplexed scan of a hex value onto shared 7-seg digits.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_controller
    import hexdisp_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int ON_CYC    = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  lzs,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CNT_MAX = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DW      = $clog2(DIGITS);

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);

    scan_state_t           state_q, state_d;
    logic [DW-1:0]         dig_q, dig_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  run_q, run_d;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic [4*DIGITS-1:0]   shown_q, shown_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  fd_q, fd_d;

    logic [3:0]            w_nib;
    logic [6:0]            w_dec_seg;
    logic [DIGITS-1:0]     w_supp;
    logic                  w_zero_above;

    always_comb begin
        state_d   = state_q;
        dig_d     = dig_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        shown_d   = shown_q;
        pending_d = load ? value : pending_q;
        fd_d      = 1'b0;

        if (!enable) begin
            state_d = BLANK;
            dig_d   = '0;
            cnt_d   = '0;
            run_d   = 1'b0;
        end else if (!run_q) begin
            // First edge of a run opens a fresh frame with the pending value.
            state_d = BLANK;
            dig_d   = '0;
            cnt_d   = '0;
            run_d   = 1'b1;
            shown_d = pending_q;
        end else begin
            if (state_q == BLANK) begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                if (cnt_q == ON_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (dig_q == DIG_LAST) begin
                        dig_d   = '0;
                        shown_d = load ? value : pending_q;
                    end else begin
                        dig_d = dig_q + DW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // Pulse coincides with the final lit cycle of the last digit.
            fd_d = (state_d == SHOW) && (cnt_d == ON_LAST) && (dig_d == DIG_LAST);
        end
    end

    always_comb begin
        w_supp       = '0;
        w_zero_above = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            w_zero_above = w_zero_above && (shown_d[4*d +: 4] == 4'h0);
            w_supp[d]    = w_zero_above;
        end
    end

    assign w_nib = shown_d[{dig_d, 2'b00} +: 4];

    hex_segment_decoder u_dec (
        .nibble_i (w_nib),
        .seg_o    (w_dec_seg)
    );

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (state_d == SHOW) begin
            an_d  = ~(DIGITS'(1) << dig_d);
            seg_d = (lzs && w_supp[dig_d]) ? SEG_BLANK : w_dec_seg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BLANK;
            dig_q     <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            pending_q <= '0;
            shown_q   <= '0;
            seg_q     <= SEG_BLANK;
            an_q      <= '1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            dig_q     <= dig_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            pending_q <= pending_d;
            shown_q   <= shown_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule : hex_scan_controller
`default_nettype wire

// File: tb/tb_hex_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_scan_controller
// Description : Scoreboard bench for hex_scan_controller (4 digits, 4/1 slots).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scan_controller;

    localparam int DIGITS    = 4;
    localparam int ON_CYC    = 4;
    localparam int BLANK_CYC = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic        lzs = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    // Entry: {an[3:0], seg[6:0], frame_done}
    logic [11:0] exp_q[$];

    hex_scan_controller #(
        .DIGITS    (DIGITS),
        .ON_CYC    (ON_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .lzs        (lzs),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'h40;  4'h1: seg_of = 7'h79;
            4'h2: seg_of = 7'h24;  4'h3: seg_of = 7'h30;
            4'h4: seg_of = 7'h19;  4'h5: seg_of = 7'h12;
            4'h6: seg_of = 7'h02;  4'h7: seg_of = 7'h78;
            4'h8: seg_of = 7'h00;  4'h9: seg_of = 7'h10;
            4'hA: seg_of = 7'h08;  4'hB: seg_of = 7'h03;
            4'hC: seg_of = 7'h46;  4'hD: seg_of = 7'h21;
            4'hE: seg_of = 7'h06;  default: seg_of = 7'h0E;
        endcase
    endfunction

    // Queue the first n lit cycles of a frame showing v with suppression z.
    task automatic push_frame(input logic [15:0] v, input bit z, input int n);
        for (int k = 0; k < n; k++) begin
            int          d;
            logic [15:0] hi;
            logic [3:0]  a;
            logic [6:0]  s;
            d  = k / ON_CYC;
            hi = v >> (4 * d);
            a  = ~(4'b0001 << d);
            s  = (z && d > 0 && hi == 16'h0) ? 7'h7F : seg_of(hi[3:0]);
            exp_q.push_back({a, s, (k == DIGITS * ON_CYC - 1)});
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (an !== 4'hF) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scan_unexpected: got an=%b seg=%b fd=%b, want dark (cycle %0d)",
                             an, seg, frame_done, cyc);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    if ({an, seg, frame_done} !== e) begin
                        n_fail++;
                        $display("FAIL scan_lit: got an=%b seg=%b fd=%b, want an=%b seg=%b fd=%b (cycle %0d)",
                                 an, seg, frame_done, e[11:8], e[7:1], e[0], cyc);
                    end
                end
            end else begin
                n_checks++;
                if (seg !== 7'h7F || frame_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL scan_dark: got seg=%b fd=%b, want seg=1111111 fd=0 (cycle %0d)",
                             seg, frame_done, cyc);
                end
            end
        end
    end

    initial begin
        enable = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("rst_an", 16'(an), 16'hF);
        check("rst_seg", 16'(seg), 16'h7F);
        check("rst_fd", 16'(frame_done), 16'h0);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;

        // Frame 1: zeros; a mid-frame load must not disturb it.
        push_frame(16'h0000, 1'b0, 16);
        step_to(1);  check("c1_blank_an", 16'(an), 16'hF);
        step_to(2);  check("c2_an", 16'(an), 16'hE);
                     check("c2_seg", 16'(seg), 16'h40);
        step_to(5);  check("c5_an", 16'(an), 16'hE);
        step_to(6);  check("c6_blank_an", 16'(an), 16'hF);
        step_to(7);  check("c7_an", 16'(an), 16'hD);
        step_to(8);  load = 1'b1; value = 16'h1A3F;
        step_to(9);  load = 1'b0; value = 16'h0;
        step_to(19); check("c19_fd", 16'(frame_done), 16'h0);
        step_to(20); check("c20_fd", 16'(frame_done), 16'h1);
        push_frame(16'h1A3F, 1'b0, 16);

        // Load exactly in the boundary cycle of frame 2.
        step_to(40); check("c40_fd", 16'(frame_done), 16'h1);
        load = 1'b1; value = 16'hBEEF;
        push_frame(16'hBEEF, 1'b0, 16);
        step_to(41); load = 1'b0; value = 16'h0;
        step_to(60); push_frame(16'hBEEF, 1'b0, 16);

        // Leading-zero suppression.
        step_to(70); lzs = 1'b1; load = 1'b1; value = 16'h0030;
        step_to(71); load = 1'b0; value = 16'h0;
        step_to(80); push_frame(16'h0030, 1'b1, 16);
        step_to(85); load = 1'b1; value = 16'h0000;
        step_to(86); load = 1'b0;
        step_to(100); push_frame(16'h0000, 1'b1, 16);

        // Drop enable while digit 2 is lit.
        step_to(120); lzs = 1'b0; push_frame(16'h0000, 1'b0, 10);
        step_to(133); enable = 1'b0;
        step_to(134); check("dis_an", 16'(an), 16'hF);
                      check("dis_seg", 16'(seg), 16'h7F);
        step_to(135); load = 1'b1; value = 16'h0C05;
        step_to(136); load = 1'b0; value = 16'h0;
        step_to(137); enable = 1'b1; push_frame(16'h0C05, 1'b0, 16);
        step_to(138); check("reen_blank_an", 16'(an), 16'hF);
        step_to(139); check("reen_an", 16'(an), 16'hE);
                      check("reen_seg", 16'(seg), 16'h12);
        step_to(156); check("reen_fd19", 16'(frame_done), 16'h0);
        step_to(157); check("reen_fd20", 16'(frame_done), 16'h1);
        push_frame(16'h0C05, 1'b0, 2);

        // Asynchronous reset in the middle of a lit digit.
        step_to(158); load = 1'b1; value = 16'h7777;
        step_to(159); load = 1'b0; value = 16'h0;
        step_to(160);
        #6 reset = 1'b1;
        #1;
        check("areset_an", 16'(an), 16'hF);
        check("areset_seg", 16'(seg), 16'h7F);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        push_frame(16'h0000, 1'b0, 16);
        step_to(2);  check("post_rst_seg", 16'(seg), 16'h40);
        step_to(20); check("post_rst_fd", 16'(frame_done), 16'h1);
        push_frame(16'h0000, 1'b0, 1);
        step_to(22);
        @(negedge clk);
        #1;
        check("queue_drained", 16'(exp_q.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_hex_scan_controller
`default_nettype wire
